branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Control-step sequencer for conditional branch instructions (brzr, brnz, brpl, brmi).
- Drives the datapath strobes that load the CON flip-flop from the bus, form PC + sign-extended offset in the ALU, and commit the new PC only when the condition holds.
- Sits beside the main control unit, which hands off after fetch/decode via Start and resumes on Done.
- Keeps saturating branch and taken-branch counters for debug.

Parameters:
- COUNT_W, 16, width of Branch_Count and Taken_Count.
- SKIP_NOT_TAKEN, 0, when 1 a not-taken branch bypasses the ADD_OFF step.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- Start  input  1  one-cycle request from the control unit; decoded branch is in IR
- Count_Clr  input  1  synchronous clear of both counters
- CON_Out  input  1  registered condition result from the CON flip-flop
- Busy  output  1  high while a branch sequence is in progress
- Done  output  1  one-cycle pulse in the final step
- Taken  output  1  registered result of the last completed branch
- Gra  output  1  select Ra field for register read
- Rout  output  1  drive selected register onto the bus
- CON_In  output  1  load enable for the CON flip-flop
- PCout  output  1  drive PC onto the bus
- Yin  output  1  load Y register
- Cout  output  1  drive sign-extended C onto the bus
- ALU_Add  output  1  ALU operation select = ADD
- Zin  output  1  load Z register
- Zlowout  output  1  drive Z[31:0] onto the bus
- PCin  output  1  load PC from the bus
- Branch_Count  output  COUNT_W  completed branches, saturating
- Taken_Count  output  COUNT_W  taken branches, saturating

Behaviour:
- States: IDLE, EVAL, PC_TO_Y, ADD_OFF, COMMIT. FSM is Moore; all strobes decode from the state register. Taken and the counters are registered.
- Reset (reset=0 at a rising edge):
  - state goes to IDLE; Taken, Branch_Count and Taken_Count clear to 0.
  - All strobes, Busy and Done are 0 in IDLE.
  - Reset overrides every other input, including mid-sequence; no PCin is issued after reset.
- IDLE:
  - Start=1 -> EVAL on the next edge.
  - Start=0 -> stay in IDLE.
- EVAL: Gra=Rout=CON_In=1. The CON flip-flop captures the condition at the end of this cycle. Always -> PC_TO_Y.
- PC_TO_Y: PCout=Yin=1. CON_Out is valid from this cycle onward.
  - SKIP_NOT_TAKEN=1 and CON_Out=0 -> COMMIT.
  - Otherwise -> ADD_OFF.
- ADD_OFF: Cout=ALU_Add=Zin=1. -> COMMIT.
- COMMIT:
  - Done=1.
  - Zlowout=PCin=CON_Out, so the PC is unchanged when not taken.
  - At the end of the cycle: Taken<=CON_Out; Branch_Count increments; Taken_Count increments if CON_Out=1.
  - Each counter saturates at 2^COUNT_W-1.
  - -> IDLE.
- Busy=1 in EVAL, PC_TO_Y, ADD_OFF and COMMIT.
- Latency from the Start edge to Done:
  - 4 cycles in the normal path.
  - 3 cycles when SKIP_NOT_TAKEN=1 and the branch is not taken.
- Start while Busy=1 is ignored and not queued. Start in the same cycle as COMMIT is also ignored; the FSM returns to IDLE.
- Back-to-back branches: Start in the first IDLE cycle after COMMIT enters EVAL on the next edge. The minimum issue interval is 5 cycles.
- Count_Clr=1 zeroes both counters on the next edge and takes priority over a COMMIT increment in the same cycle. Taken is unaffected.
- Strobe exclusivity: at most one bus driver (Rout, PCout, Cout, Zlowout) is high in any cycle.

Test Plan:
1. Reset: reset=0 for 2 cycles, then 1 -> all strobes, Busy and Done are 0; both counters read 0.
2. brzr taken, bus value 0x00000000, CON FF captures 1 with SKIP_NOT_TAKEN=0:
   - Start pulse -> EVAL, PC_TO_Y, ADD_OFF, COMMIT on the next 4 edges.
   - PCin=1 with Done=1; Taken=1; Branch_Count=1; Taken_Count=1.
3. brmi not taken, bus value 0x00000005, CON_Out=0:
   - With SKIP_NOT_TAKEN=0 -> 4-cycle sequence, PCin=0 in COMMIT, Taken=0, Branch_Count increments, Taken_Count unchanged.
   - With SKIP_NOT_TAKEN=1 -> ADD_OFF skipped; Done 3 cycles after Start.
4. Start re-pulsed during ADD_OFF, then again in COMMIT -> both ignored; exactly one Done; FSM returns to IDLE.
5. reset=0 asserted in ADD_OFF -> next cycle is IDLE with all strobes 0; no PCin or Done; counters are 0.
6. COUNT_W=2 with 5 taken branches -> counters read 3 and stay at 3. Count_Clr=1 in a COMMIT cycle -> both counters read 0 on the next cycle.

Source files
------------

// File: rtl/branch_sequencer.sv
// Conditional-branch control-step sequencer: EVAL -> PC_TO_Y -> [ADD_OFF] -> COMMIT, Done 4 (or 3) cycles after Start.
// No backpressure: Start while busy, or in the COMMIT cycle, is dropped rather than queued.
module branch_sequencer #(
  parameter int COUNT_W        = 16,
  parameter bit SKIP_NOT_TAKEN = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Start,
  input  logic               Count_Clr,
  input  logic               CON_Out,
  output logic               Busy,
  output logic               Done,
  output logic               Taken,
  output logic               Gra,
  output logic               Rout,
  output logic               CON_In,
  output logic               PCout,
  output logic               Yin,
  output logic               Cout,
  output logic               ALU_Add,
  output logic               Zin,
  output logic               Zlowout,
  output logic               PCin,
  output logic [COUNT_W-1:0] Branch_Count,
  output logic [COUNT_W-1:0] Taken_Count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    PC_TO_Y = 3'd2,
    ADD_OFF = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic                 taken_q, taken_d;
  logic [COUNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [COUNT_W-1:0]   taken_cnt_q, taken_cnt_d;

  always_comb begin
    state_d      = state_q;
    taken_d      = taken_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    case (state_q)
      IDLE:    if (Start) state_d = EVAL;
      EVAL:    state_d = PC_TO_Y;
      PC_TO_Y: state_d = (SKIP_NOT_TAKEN && !CON_Out) ? COMMIT : ADD_OFF;
      ADD_OFF: state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == COMMIT) begin
      taken_d = CON_Out;
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + COUNT_W'(1);
      if (CON_Out && (taken_cnt_q != CNT_MAX)) taken_cnt_d = taken_cnt_q + COUNT_W'(1);
    end

    // Clear wins over a same-cycle commit increment; Taken is left alone.
    if (Count_Clr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      taken_q      <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      taken_q      <= taken_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Moore decode: each step owns exactly one bus driver.
  assign Gra     = (state_q == EVAL);
  assign Rout    = (state_q == EVAL);
  assign CON_In  = (state_q == EVAL);
  assign PCout   = (state_q == PC_TO_Y);
  assign Yin     = (state_q == PC_TO_Y);
  assign Cout    = (state_q == ADD_OFF);
  assign ALU_Add = (state_q == ADD_OFF);
  assign Zin     = (state_q == ADD_OFF);
  assign Zlowout = (state_q == COMMIT) && CON_Out;
  assign PCin    = (state_q == COMMIT) && CON_Out;
  assign Done    = (state_q == COMMIT);
  assign Busy    = (state_q != IDLE);

  assign Taken        = taken_q;
  assign Branch_Count = branch_cnt_q;
  assign Taken_Count  = taken_cnt_q;

endmodule
